move_queue: RTL
===============

Name: move_queue

Overview:
- Buffers coordinated-move descriptors between the SPI message decoder and the step timing engine.
- Upstream, it receives a move header (direction) followed by three 64-bit words: duration, increment, increment-increment.
- It assembles each message into one descriptor and stores it in a circular FIFO.
- Downstream, it presents the head descriptor to the step engine, which pops it when the move completes.

Parameters:
- DEPTH_BITS, 2, log2 of queue depth (DEPTH = 4 entries).
- WORD_W, 64, width of the duration, increment and increment-increment fields.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- hdr_valid  in  1  one-cycle strobe: start of a move message
- hdr_dir  in  1  move direction, sampled with hdr_valid
- word_valid  in  1  one-cycle strobe: payload word present
- word_data  in  WORD_W  payload word
- mv_valid  out  1  head entry available
- mv_dir  out  1  head direction
- mv_duration  out  WORD_W  head move duration (ticks)
- mv_increment  out  WORD_W  head increment (signed)
- mv_incinc  out  WORD_W  head increment-increment (signed)
- mv_pop  in  1  step engine consumed head entry
- count  out  DEPTH_BITS+1  number of stored entries
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a completed message was dropped because the queue was full
- underrun  out  1  sticky: mv_pop was asserted while the queue was empty
- proto_err  out  1  sticky: hdr_valid arrived mid-message
- clear_err  in  1  clears all three sticky flags

Behaviour:
- Reset (resetn low, asynchronous):
  - Pointers and count go to 0; FSM goes to IDLE.
  - Staging registers and all sticky flags go to 0.
  - mv_valid = 0, full = 0; mv_* data outputs = 0.
- Assembler FSM states: IDLE, W_DUR, W_INC, W_ACC.
  - IDLE + hdr_valid: latch hdr_dir, go to W_DUR. word_valid in IDLE is ignored.
  - W_DUR + word_valid: stage duration, go to W_INC.
  - W_INC + word_valid: stage increment, go to W_ACC.
  - W_ACC + word_valid: commit {dir, duration, increment, word_data} at wr_ptr, go to IDLE.
- hdr_valid in any non-IDLE state:
  - The partial message is abandoned and proto_err is set.
  - The new header is latched and the FSM goes to W_DUR.
- hdr_valid and word_valid in the same cycle: the header wins and the word is ignored.
- Commit when count == DEPTH and mv_pop is low:
  - The entry is dropped and overflow is set; pointers are unchanged.
  - The FSM still returns to IDLE.
- Commit with simultaneous mv_pop while full: both are accepted and count is unchanged.
- Pop:
  - mv_pop with count > 0: rd_ptr increments and count decrements.
  - mv_pop with count == 0: ignored and underrun is set.
- Count update:
  - Push alone: +1. Pop alone: -1. Push and pop together: unchanged.
  - Pointers wrap modulo DEPTH.
- Latency:
  - A commit in cycle N makes the entry visible (mv_valid high when the queue was empty) in N+1.
  - A pop in cycle N presents the next head in N+1.
  - An entry committed into an empty queue with a simultaneous pop: the pop is an underrun; the entry is stored.
- Output timing:
  - mv_valid = (count != 0), registered-derived with no combinational path from the inputs.
  - mv_* outputs reflect mem[rd_ptr].
  - When the queue is empty, mv_* hold the last value and downstream ignores them.
- clear_err: sticky flags go to 0 in the next cycle. A set event in the same cycle as clear_err wins (flag = 1).
- Arithmetic: all payload fields are passed through unmodified; no sign extension or arithmetic is applied inside this block.

Optional Feature:
- MOVE_QUEUE_FLUSH_EN defined:
  - Adds input flush (1 bit).
  - flush is synchronous and takes effect next cycle: pointers, count and FSM go to IDLE.
  - Sticky flags are untouched.
  - flush has priority over push, pop and header in the same cycle.
- MOVE_QUEUE_FLUSH_EN undefined: the flush port does not exist; the queue empties only by pop or reset.

Decomposition:
- Shared package move_pkg:
  - FSM state encoding.
  - MOVE_PAYLOAD_WORDS = 3.
  - Descriptor field widths and the packed descriptor layout {dir, duration, increment, incinc} (1 + 3*WORD_W bits).
- One sub-module, move_queue_mem:
  - Register-array storage, DEPTH x descriptor width.
  - One synchronous write port and one asynchronous read port indexed by rd_ptr.

Test Plan:
- Reset with a partial message pending (after the header and one word) -> count = 0, mv_valid = 0, FSM in IDLE, flags = 0.
- Header dir = 1, words 1000, 0x10, -1 -> one cycle after the 3rd word: mv_valid = 1, mv_dir = 1, mv_duration = 1000, mv_increment = 0x10, mv_incinc = 0xFFFF_FFFF_FFFF_FFFF, count = 1.
- Push 5 messages with no pop -> count = 4, full = 1, overflow = 1; pop 4 times -> heads appear in order 1, 2, 3, 4, then mv_valid = 0.
- Queue full, 3rd word committed in the same cycle as mv_pop -> count stays 4, overflow stays 0, new entry appears at the tail.
- Header, one word, then a second header followed by 3 words -> proto_err = 1, exactly one entry stored, holding the second message's values.
- mv_pop while empty -> underrun = 1; clear_err pulse -> underrun = 0 next cycle. With MOVE_QUEUE_FLUSH_EN: flush with 3 entries queued -> count = 0 next cycle.

Source files
------------

// File: rtl/move_queue_pkg.sv
// Shared definitions for the move queue: assembler FSM encoding, payload
// word count, default widths and the packed descriptor layout
// {dir, duration, increment, incinc}.
package move_pkg;

    localparam int MOVE_PAYLOAD_WORDS = 3;
    localparam int MOVE_WORD_W        = 64;
    localparam int MOVE_DEPTH_BITS    = 2;

    // Assembler progress through one move message.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        W_DUR = 2'd1,
        W_INC = 2'd2,
        W_ACC = 2'd3
    } move_state_e;

    // Descriptor layout at the default word width; the RTL uses the same
    // field order as a flat vector so WORD_W can be overridden.
    typedef struct packed {
        logic                   dir;
        logic [MOVE_WORD_W-1:0] duration;
        logic [MOVE_WORD_W-1:0] increment;
        logic [MOVE_WORD_W-1:0] incinc;
    } move_desc_t;

    // Stored descriptor width for a given payload word width.
    function automatic int desc_width(input int word_w);
        return 1 + MOVE_PAYLOAD_WORDS * word_w;
    endfunction

endpackage

// File: rtl/move_queue_if.sv
// Bundle of upstream message, downstream head and status/control signals of
// the move queue. The flush signal exists only with MOVE_QUEUE_FLUSH_EN.
interface move_queue_if #(
    parameter int WORD_W     = 64,
    parameter int DEPTH_BITS = 2
);
    logic                  hdr_valid;
    logic                  hdr_dir;
    logic                  word_valid;
    logic [WORD_W-1:0]     word_data;
    logic                  mv_valid;
    logic                  mv_dir;
    logic [WORD_W-1:0]     mv_duration;
    logic [WORD_W-1:0]     mv_increment;
    logic [WORD_W-1:0]     mv_incinc;
    logic                  mv_pop;
    logic [DEPTH_BITS:0]   count;
    logic                  full;
    logic                  overflow;
    logic                  underrun;
    logic                  proto_err;
    logic                  clear_err;
`ifdef MOVE_QUEUE_FLUSH_EN
    logic                  flush;
`endif

    // Message source / step engine side.
    modport master (
        output hdr_valid, hdr_dir, word_valid, word_data, mv_pop, clear_err,
`ifdef MOVE_QUEUE_FLUSH_EN
        output flush,
`endif
        input  mv_valid, mv_dir, mv_duration, mv_increment, mv_incinc,
        input  count, full, overflow, underrun, proto_err
    );

    // Queue side.
    modport slave (
        input  hdr_valid, hdr_dir, word_valid, word_data, mv_pop, clear_err,
`ifdef MOVE_QUEUE_FLUSH_EN
        input  flush,
`endif
        output mv_valid, mv_dir, mv_duration, mv_increment, mv_incinc,
        output count, full, overflow, underrun, proto_err
    );
endinterface

// File: rtl/move_queue_mem.sv
// Descriptor storage: register array with one synchronous write port and one
// asynchronous read port.
module move_queue_mem #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 193
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    // Write the committed descriptor into its slot.
    // NOTE: the array is reset because the head outputs read it directly and
    // must show zero after reset; an unreset array would expose X there.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < (1 << ADDR_W); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/move_queue.sv
// Move queue: assembles header + three payload words into a descriptor and
// buffers it in a circular FIFO for the step engine.
// Optional build macro MOVE_QUEUE_FLUSH_EN adds a synchronous flush input.
module move_queue
    import move_pkg::*;
#(
    parameter int DEPTH_BITS = MOVE_DEPTH_BITS,
    parameter int WORD_W     = MOVE_WORD_W
) (
    input logic         clk,
    input logic         resetn,
    move_queue_if.slave bus
);
    localparam int                  DEPTH     = 1 << DEPTH_BITS;
    localparam int                  DESC_W    = desc_width(WORD_W);
    localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS+1)'(DEPTH);

    move_state_e           r_state, w_state_nxt;
    logic                  r_dir;
    logic [WORD_W-1:0]     r_dur, r_inc;
    logic [DEPTH_BITS-1:0] r_wr_ptr, r_rd_ptr;
    logic [DEPTH_BITS:0]   r_count;
    logic                  r_overflow, r_underrun, r_proto_err;

    logic                  w_flush, w_commit, w_full, w_push, w_pop_ok;
    logic                  w_ovf_evt, w_unr_evt, w_proto_evt;
    logic [DESC_W-1:0]     w_wdata, w_rdata;

`ifdef MOVE_QUEUE_FLUSH_EN
    assign w_flush = bus.flush;
`else
    assign w_flush = 1'b0;
`endif

    // A header always wins over a word in the same cycle, so it suppresses the commit.
    assign w_commit    = !w_flush && (r_state == W_ACC) && bus.word_valid && !bus.hdr_valid;
    assign w_full      = (r_count == DEPTH_CNT);
    assign w_pop_ok    = !w_flush && bus.mv_pop && (r_count != '0);
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign w_push      = w_commit && (!w_full || bus.mv_pop);
    assign w_ovf_evt   = w_commit && w_full && !bus.mv_pop;
    assign w_unr_evt   = !w_flush && bus.mv_pop && (r_count == '0);
    assign w_proto_evt = !w_flush && bus.hdr_valid && (r_state != IDLE);
    assign w_wdata     = {r_dir, r_dur, r_inc, bus.word_data};

    // Assembler state register.
    // NOTE: all sequential state uses non-blocking assignment so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Assembler next state; a header restarts the message from any state.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_state_nxt = r_state;
        if (w_flush) begin
            w_state_nxt = IDLE;
        end else if (bus.hdr_valid) begin
            w_state_nxt = W_DUR;
        end else if (bus.word_valid) begin
            unique case (r_state)
                W_DUR:   w_state_nxt = W_INC;
                W_INC:   w_state_nxt = W_ACC;
                W_ACC:   w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Staging registers for direction, duration and increment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dir <= 1'b0;
            r_dur <= '0;
            r_inc <= '0;
        end else if (!w_flush) begin
            if (bus.hdr_valid) begin
                r_dir <= bus.hdr_dir;
            end else if (bus.word_valid) begin
                if (r_state == W_DUR) r_dur <= bus.word_data;
                if (r_state == W_INC) r_inc <= bus.word_data;
            end
        end
    end

    // Circular pointers and occupancy count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop_ok)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop_ok) r_count <= r_count - 1'b1;
        end
    end

    // Sticky error flags; a new event beats a simultaneous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overflow  <= 1'b0;
            r_underrun  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_evt   || (r_overflow  && !bus.clear_err);
            r_underrun  <= w_unr_evt   || (r_underrun  && !bus.clear_err);
            r_proto_err <= w_proto_evt || (r_proto_err && !bus.clear_err);
        end
    end

    move_queue_mem #(
        .ADDR_W (DEPTH_BITS),
        .DATA_W (DESC_W)
    ) u_mem (
        .clk     (clk),
        .resetn  (resetn),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign bus.mv_valid = (r_count != '0);
    assign {bus.mv_dir, bus.mv_duration, bus.mv_increment, bus.mv_incinc} = w_rdata;
    assign bus.count     = r_count;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.underrun  = r_underrun;
    assign bus.proto_err = r_proto_err;
endmodule
